// File: rtl/cpu_mc_param.sv
// Parametrised multi-cycle CPU core with req/ack instruction and data ports.
// Instructions move through FETCH, DECODE, EXEC, MEM and WB. HLT or an undefined opcode stops the core.
module cpu_mc_param #(
    parameter int            DW       = 32,
    parameter int            AW       = 10,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          imem_ack,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack,
    output logic          halted,
    output logic          illegal,
    output logic          retire,
    output logic [AW-1:0] pc_out
);

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_AND   = 6'd2;
    localparam logic [5:0] OP_OR    = 6'd3;
    localparam logic [5:0] OP_LST   = 6'd4;
    localparam logic [5:0] OP_RST   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd6;
    localparam logic [5:0] OP_ST    = 6'd7;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SUBI  = 6'd9;
    localparam logic [5:0] OP_BEQZ  = 6'd10;
    localparam logic [5:0] OP_BNEQZ = 6'd11;
    localparam logic [5:0] OP_HLT   = 6'd63;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] pc, pc_n;
    logic [31:0]   ir;
    logic [DW-1:0] a, b, imm, aluout, mdr;
    logic [DW-1:0] rf [32];

    logic [5:0]    op;
    logic [4:0]    rs, rt, rd;
    logic [DW-1:0] rs_val, rt_val, imm_n, alu_n, wr_data;
    logic [4:0]    wr_addr;
    logic          wr_en, retire_n, illegal_n, legal, is_branch, taken;

    assign op  = ir[31:26];
    assign rs  = ir[25:21];
    assign rt  = ir[20:16];
    assign rd  = ir[15:11];

    assign rs_val = (rs == 5'd0) ? '0 : rf[rs];
    assign rt_val = (rt == 5'd0) ? '0 : rf[rt];
    assign imm_n  = DW'($signed(ir[15:0]));

    assign legal     = (op <= OP_BNEQZ) || (op == OP_HLT);
    assign is_branch = (op == OP_BEQZ) || (op == OP_BNEQZ);
    assign taken     = (op == OP_BEQZ) ? (a == '0) : (a != '0);

    assign imem_addr  = pc;
    assign pc_out     = pc;
    assign dmem_addr  = aluout[AW-1:0];
    assign dmem_wdata = b;

    always_comb begin
        alu_n = a + imm;
        case (op)
            OP_ADD:  alu_n = a + b;
            OP_SUB:  alu_n = a - b;
            OP_AND:  alu_n = a & b;
            OP_OR:   alu_n = a | b;
            OP_LST:  alu_n = a << b;
            OP_RST:  alu_n = a >> b;
            OP_SUBI: alu_n = a - imm;
            default: alu_n = a + imm;
        endcase
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        wr_en     = 1'b0;
        wr_addr   = rt;
        wr_data   = (op == OP_LW) ? mdr : aluout;
        retire_n  = 1'b0;
        illegal_n = illegal;
        case (state)
            S_FETCH: begin
                if (imem_req && imem_ack) state_n = S_DECODE;
            end
            S_DECODE: begin
                if (op == OP_HLT) begin
                    state_n  = S_HALT;
                    retire_n = 1'b1;
                end else if (!legal) begin
                    state_n   = S_HALT;
                    illegal_n = 1'b1;
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_n     = taken ? pc + imm[AW-1:0] : pc + AW'(1);
                    retire_n = 1'b1;
                    state_n  = S_FETCH;
                end else begin
                    pc_n    = pc + AW'(1);
                    state_n = (op == OP_LW || op == OP_ST) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                if (dmem_req && dmem_ack) begin
                    if (op == OP_ST) begin
                        retire_n = 1'b1;
                        state_n  = S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end
            end
            S_WB: begin
                wr_en    = 1'b1;
                wr_addr  = (op <= OP_RST) ? rd : rt;
                retire_n = 1'b1;
                state_n  = S_FETCH;
            end
            default: state_n = S_HALT;
        endcase
    end

    // Handshake and status outputs are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            imm      <= '0;
            aluout   <= '0;
            mdr      <= '0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
            retire   <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            imem_req <= (state_n == S_FETCH);
            dmem_req <= (state_n == S_MEM);
            dmem_we  <= (state_n == S_MEM) && (op == OP_ST);
            halted   <= (state_n == S_HALT);
            illegal  <= illegal_n;
            retire   <= retire_n;
            if (state == S_FETCH && imem_req && imem_ack) ir <= imem_rdata;
            if (state == S_DECODE) begin
                a   <= rs_val;
                b   <= rt_val;
                imm <= imm_n;
            end
            if (state == S_EXEC) aluout <= alu_n;
            if (state == S_MEM && dmem_req && dmem_ack) mdr <= dmem_rdata;
            if (wr_en && wr_addr != 5'd0) rf[wr_addr] <= wr_data;
        end
    end

endmodule
